// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM-WB stage.
// A miss writes back a dirty victim and then refills the line one word at a time.
module dcache_dm_wb #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [3:0]  wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int WORDS = 1 << LINE_ADDR_LEN;
    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;
    localparam logic [LINE_ADDR_LEN-1:0] FIRST_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL
    } state_t;

    // Valid/dirty bits are reset; data and tags deliberately are not.
    logic [31:0]             data_mem [SETS][WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_mem  [SETS];

    state_t                   state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] counter_q, counter_d;
    logic                     mem_rd_req_q, mem_rd_req_d;
    logic                     mem_wr_req_q, mem_wr_req_d;
    logic [31:0]              mem_addr_q, mem_addr_d;
    logic [31:0]              mem_wdata_q, mem_wdata_d;
    logic [31:0]              hit_count_q, hit_count_d;
    logic [31:0]              miss_count_q, miss_count_d;
    logic [SETS-1:0]          valid_q, valid_d;
    logic [SETS-1:0]          dirty_q, dirty_d;

    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag_in;
    logic                     req;
    logic                     is_store;
    logic                     hit;
    logic                     ack;
    logic                     miss_o;
    logic                     store_en;
    logic                     refill_en;
    logic                     tag_en;
    logic                     unused_byte_bits;

    assign word_idx         = addr[LINE_ADDR_LEN+1:2];
    assign set_idx          = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag_in           = addr[31:SET_ADDR_LEN+LINE_ADDR_LEN+2];
    assign unused_byte_bits = &{1'b0, addr[1:0]};

    assign req      = rd_req | (|wr_req);
    assign is_store = |wr_req;
    assign hit      = valid_q[set_idx] && (tag_mem[set_idx] == tag_in);
    // An ack only counts while one of our requests is actually on the bus.
    assign ack      = mem_ack & (mem_rd_req_q | mem_wr_req_q);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_wr_req_d = mem_wr_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        miss_o       = 1'b0;
        store_en     = 1'b0;
        refill_en    = 1'b0;
        tag_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        hit_count_d = hit_count_q + 32'd1;
                        if (is_store) begin
                            store_en         = 1'b1;
                            dirty_d[set_idx] = 1'b1;
                        end
                    end else begin
                        miss_o       = 1'b1;
                        miss_count_d = miss_count_q + 32'd1;
                        counter_d    = FIRST_WORD;
                        if (valid_q[set_idx] && dirty_q[set_idx]) begin
                            state_d      = S_WRITEBACK;
                            mem_wr_req_d = 1'b1;
                            mem_addr_d   = {tag_mem[set_idx], set_idx, FIRST_WORD, 2'b00};
                            mem_wdata_d  = data_mem[set_idx][FIRST_WORD];
                        end else begin
                            state_d      = S_REFILL;
                            mem_rd_req_d = 1'b1;
                            mem_addr_d   = {tag_in, set_idx, FIRST_WORD, 2'b00};
                        end
                    end
                end
            end

            S_WRITEBACK: begin
                miss_o = 1'b1;
                if (mem_wr_req_q) begin
                    if (ack) begin
                        mem_wr_req_d = 1'b0;
                        if (counter_q == LAST_WORD) begin
                            counter_d = FIRST_WORD;
                            state_d   = S_REFILL;
                        end else begin
                            counter_d = counter_q + 1'b1;
                        end
                    end
                end else begin
                    // Gap cycle after an ack: present the next victim word.
                    mem_wr_req_d = 1'b1;
                    mem_addr_d   = {tag_mem[set_idx], set_idx, counter_q, 2'b00};
                    mem_wdata_d  = data_mem[set_idx][counter_q];
                end
            end

            S_REFILL: begin
                miss_o = 1'b1;
                if (mem_rd_req_q) begin
                    if (ack) begin
                        refill_en    = 1'b1;
                        mem_rd_req_d = 1'b0;
                        if (counter_q == LAST_WORD) begin
                            tag_en           = 1'b1;
                            valid_d[set_idx] = 1'b1;
                            dirty_d[set_idx] = 1'b0;
                            counter_d        = FIRST_WORD;
                            state_d          = S_IDLE;
                        end else begin
                            counter_d = counter_q + 1'b1;
                        end
                    end
                end else begin
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = {tag_in, set_idx, counter_q, 2'b00};
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            counter_q    <= '0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (store_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_req[b]) begin
                        data_mem[set_idx][word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            if (refill_en) begin
                data_mem[set_idx][counter_q] <= mem_rdata;
            end
            if (tag_en) begin
                tag_mem[set_idx] <= tag_in;
            end
        end
    end

    assign rd_data    = data_mem[set_idx][word_idx];
    assign miss       = miss_o;
    assign mem_rd_req = mem_rd_req_q;
    assign mem_wr_req = mem_wr_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Self-checking bench for dcache_dm_wb: directed scenarios followed by random
// traffic, checked against a line-level cache model and a word-addressed memory.
module tb_dcache_dm_wb;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [3:0]  wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_dm_wb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .miss       (miss),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 0;
    bit spurious_en = 0;
    int ack_num = 0;

    // {is_write, word address, write data}
    logic [64:0] exp_q[$];
    logic [31:0] main_mem [logic [31:0]];

    // Cache model: 16 lines of 8 words, tag = addr[31:9].
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [22:0] m_tag   [16];
    logic [31:0] m_data  [16][8];
    int          m_hits;
    int          m_misses;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        return main_mem.exists(a) ? main_mem[a] : a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hits   = 0;
        m_misses = 0;
        exp_q.delete();
    endtask

    task automatic model_access(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                                output bit hit, output logic [31:0] rdv);
        logic [3:0]  s;
        logic [2:0]  w;
        logic [22:0] t;
        logic [31:0] la;
        s = a[8:5];
        w = a[4:2];
        t = a[31:9];
        hit = m_valid[s] && (m_tag[s] == t);
        if (!hit) begin
            m_misses++;
            if (m_valid[s] && m_dirty[s]) begin
                for (int i = 0; i < 8; i++) begin
                    la = {m_tag[s], s, 3'(i), 2'b00};
                    exp_q.push_back({1'b1, la, m_data[s][i]});
                end
            end
            for (int i = 0; i < 8; i++) begin
                la = {t, s, 3'(i), 2'b00};
                exp_q.push_back({1'b0, la, 32'h0});
                m_data[s][i] = mem_value(la);
            end
            m_valid[s] = 1;
            m_dirty[s] = 0;
            m_tag[s]   = t;
        end
        m_hits++;
        rdv = m_data[s][w];
        if (|we) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
            end
            m_dirty[s] = 1;
        end
    endtask

    // Main-memory responder: acks each word ack_delay cycles after it is requested.
    initial begin
        logic [64:0] e;
        logic [31:0] lat_addr;
        logic [31:0] lat_wdata;
        bit          active;
        int          wait_cnt;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        active    = 0;
        wait_cnt  = 0;
        lat_addr  = 32'h0;
        lat_wdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst) begin
                active   = 0;
                wait_cnt = 0;
            end else if (mem_rd_req || mem_wr_req) begin
                check_eq("mem_req_exclusive", {31'b0, mem_rd_req & mem_wr_req}, 32'h0);
                if (!active) begin
                    active    = 1;
                    wait_cnt  = 0;
                    lat_addr  = mem_addr;
                    lat_wdata = mem_wdata;
                end else begin
                    check_eq("mem_addr_stable", mem_addr, lat_addr);
                    if (mem_wr_req) check_eq("mem_wdata_stable", mem_wdata, lat_wdata);
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    active  = 0;
                    ack_num++;
                    if (exp_q.size() == 0) begin
                        check_eq("mem_extra_txn", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("mem_txn_kind", {31'b0, mem_wr_req}, {31'b0, e[64]});
                        check_eq("mem_txn_addr", mem_addr, e[63:32]);
                        if (mem_wr_req) begin
                            check_eq("mem_wb_data", mem_wdata, e[31:0]);
                            main_mem[mem_addr] = mem_wdata;
                        end else begin
                            mem_rdata = mem_value(mem_addr);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    task automatic do_access(input logic rd, input logic [3:0] we, input logic [31:0] a,
                             input logic [31:0] wd, input int exp_stall);
        bit          exp_hit;
        logic [31:0] exp_rd;
        int          stall;
        @(negedge clk);
        model_access(we, a, wd, exp_hit, exp_rd);
        rd_req  = rd;
        wr_req  = we;
        addr    = a;
        wr_data = wd;
        #1;
        check_eq("miss_first_cycle", {31'b0, miss}, {31'b0, ~exp_hit});
        stall = 0;
        while (miss && stall < 4000) begin
            stall++;
            @(negedge clk);
            #1;
        end
        if (miss) check_eq("stall_timeout", {31'b0, miss}, 32'h0);
        if (exp_stall >= 0) check_eq("stall_cycles", 32'(stall), 32'(exp_stall));
        check_eq("rd_data", rd_data, exp_rd);
        @(posedge clk);
        #1;
        check_eq("hit_count", hit_count, 32'(m_hits));
        check_eq("miss_count", miss_count, 32'(m_misses));
        check_eq("mem_txn_drained", 32'(exp_q.size()), 32'h0);
        rd_req = 1'b0;
        wr_req = 4'h0;
    endtask

    initial begin
        int          base;
        int          k;
        bit          h;
        logic [31:0] dummy;
        logic [31:0] ra;
        logic [3:0]  rwe;
        logic        rrd;

        rst     = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 4'h0;
        addr    = 32'h0;
        wr_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_miss", {31'b0, miss}, 32'h0);
        check_eq("rst_mem_rd_req", {31'b0, mem_rd_req}, 32'h0);
        check_eq("rst_mem_wr_req", {31'b0, mem_wr_req}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_hit_count", hit_count, 32'h0);
        check_eq("rst_miss_count", miss_count, 32'h0);

        // Read miss with clean refill, then byte store hit and re-read.
        ack_delay = 0;
        do_access(1'b1, 4'h0, 32'h0000_0040, 32'h0, 16);
        do_access(1'b0, 4'b0010, 32'h0000_0044, 32'h0000_AB00, 0);
        do_access(1'b1, 4'h0, 32'h0000_0044, 32'h0, 0);
        check_eq("store_merged", rd_data, 32'h0000_AB44);

        // Dirty conflict in set 2, then clean conflict back to 0x40.
        do_access(1'b1, 4'h0, 32'h0000_0240, 32'h0, 32);
        check_eq("wb_in_memory", mem_value(32'h0000_0044), 32'h0000_AB44);
        do_access(1'b1, 4'h0, 32'h0000_0040, 32'h0, 16);
        do_access(1'b1, 4'h0, 32'h0000_0044, 32'h0, 0);

        // Slow memory.
        ack_delay = 5;
        do_access(1'b1, 4'h0, 32'h0000_1040, 32'h0, -1);
        do_access(1'b1, 4'h0, 32'h0000_105C, 32'h0, 0);
        ack_delay = 0;

        // Reset in the middle of a refill.
        @(negedge clk);
        model_access(4'h0, 32'h0000_0640, 32'h0, h, dummy);
        rd_req = 1'b1;
        addr   = 32'h0000_0640;
        base   = ack_num;
        k      = 0;
        while (ack_num < base + 3 && k < 500) begin
            @(posedge clk);
            k++;
        end
        check_eq("reset_ack_wait", 32'(ack_num - base), 32'd3);
        #2;
        rst    = 1'b1;
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("midrst_mem_rd_req", {31'b0, mem_rd_req}, 32'h0);
        check_eq("midrst_mem_wr_req", {31'b0, mem_wr_req}, 32'h0);
        check_eq("midrst_hit_count", hit_count, 32'h0);
        check_eq("midrst_miss_count", miss_count, 32'h0);
        model_reset();
        rst = 1'b0;
        do_access(1'b1, 4'h0, 32'h0000_0040, 32'h0, 16);

        // Random traffic over 4 tags x 4 sets with varying memory latency.
        spurious_en = 1;
        for (int n = 0; n < 200; n++) begin
            ra  = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 2'b00};
            rwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            rrd = (rwe == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
            ack_delay = $urandom_range(0, 3);
            do_access(rrd, rwe, ra, $urandom, -1);
        end
        spurious_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
